// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
//   Contents: bus widths, implemented depth, FSM state and owner encodings,
//   grant bit positions and the out-of-range address test.
package mem_access_ctrl_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8192;

    // Depth as an address-width constant so range compares stay width-matched.
    localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_t;

    localparam int GNT_IF = 0;
    localparam int GNT_D  = 1;

    function automatic logic addr_fault(input logic [ADDR_W-1:0] addr);
        return addr >= DEPTH_LIM;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundle of fetch port, load/store port and Memory-side signals.
// Latency: n/a (wiring only).
// Backpressure: requests are held by the requester until the matching done pulse.
//   slave  : controller view (takes requests and mem_rdata, drives done/rdata/fault and mem_*).
//   master : datapath + Memory view (the opposite directions).
interface mem_access_ctrl_if import mem_access_ctrl_pkg::*; ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    logic              if_fault;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              d_fault;

    logic              memR;
    logic              memW;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter preference: 1 = the next contended grant goes to fetch.
    logic              arb_flag;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_done, if_rdata, if_fault, d_done, d_rdata, d_fault,
        output memR, memW, mem_addr, mem_wdata, arb_flag
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_done, if_rdata, if_fault, d_done, d_rdata, d_fault,
        input  memR, memW, mem_addr, mem_wdata, arb_flag
    );

endinterface

// File: rtl/mem_access_ctrl_arbiter.sv
// Two-way request arbiter (fetch vs load/store) with alternating priority under contention.
// Latency: combinational grant; the priority flag updates at the edge after a contended grant.
// Backpressure: no grant while gnt_stb is low; the losing requester simply keeps its request up.
//   Ports: clk/rst, if_req, d_req, gnt_stb in; one-hot gnt[GNT_IF/GNT_D] and fetch_pri out.
module mem_req_arbiter import mem_access_ctrl_pkg::*; (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       if_req,
    input  logic       d_req,
    input  logic       gnt_stb,
    output logic [1:0] gnt,
    output logic       fetch_pri
);

    logic contend;

    assign contend = if_req & d_req;

    always_comb begin
        gnt = 2'b00;
        if (gnt_stb) begin
            if (contend) begin
                if (fetch_pri) gnt[GNT_IF] = 1'b1;
                else           gnt[GNT_D]  = 1'b1;
            end else begin
                gnt[GNT_IF] = if_req;
                gnt[GNT_D]  = d_req;
            end
        end
    end

    // Only contended grants move the preference; lone requests leave it alone.
    always_ff @(posedge CLK) begin
        if (Reset)                   fetch_pri <= 1'b0;
        else if (gnt_stb && contend) fetch_pri <= ~fetch_pri;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer between the fetch / load-store ports and a single-port 8192x16 Memory.
// Latency: load/fetch done 3 cycles after the IDLE grant, store 2, out-of-range fault 1.
// Backpressure: one transaction at a time; losers keep req high until granted.
//   Ports: CLK, Reset (sync, active high), bus (slave modport: both request ports + mem_*).
//   memR/memW are pulsed for exactly one cycle; read data is captured one cycle after memR.
module mem_access_ctrl import mem_access_ctrl_pkg::*; (
    input  logic            CLK,
    input  logic            Reset,
    mem_access_ctrl_if.slave bus
);

    state_t            state;
    state_t            state_nxt;
    owner_t            owner;
    logic              fault_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic [1:0]        gnt;
    logic              gnt_stb;
    logic              gnt_any;
    logic              gnt_d;
    logic              fetch_pri;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic              req_fault;

    // Grants are only taken in IDLE, so DONE never overlaps a new grant.
    assign gnt_stb = (state == ST_IDLE);

    mem_req_arbiter u_arb (
        .CLK       (CLK),
        .Reset     (Reset),
        .if_req    (bus.if_req),
        .d_req     (bus.d_req),
        .gnt_stb   (gnt_stb),
        .gnt       (gnt),
        .fetch_pri (fetch_pri)
    );

    assign gnt_any   = |gnt;
    assign gnt_d     = gnt[GNT_D];
    assign req_addr  = gnt_d ? bus.d_addr : bus.if_addr;
    assign req_we    = gnt_d & bus.d_we;
    assign req_fault = addr_fault(req_addr);

    // State register
    always_ff @(posedge CLK) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (gnt_any) begin
                    if (req_fault)   state_nxt = ST_DONE;
                    else if (req_we) state_nxt = ST_WR;
                    else             state_nxt = ST_RD;
                end
            end
            ST_RD:   state_nxt = ST_CAP;
            ST_CAP:  state_nxt = ST_DONE;
            ST_WR:   state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state only, so memR and memW can never overlap.
    always_comb begin
        bus.memR    = 1'b0;
        bus.memW    = 1'b0;
        bus.if_done = 1'b0;
        bus.d_done  = 1'b0;
        case (state)
            ST_RD:   bus.memR = 1'b1;
            ST_WR:   bus.memW = 1'b1;
            ST_DONE: begin
                bus.if_done = (owner == OWNER_IF);
                bus.d_done  = (owner == OWNER_D);
            end
            default: ;
        endcase
    end

    // Request latches and read-data capture. The address is latched even on a
    // fault; it is harmless because no strobe is ever raised for a fault.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            owner      <= OWNER_D;
            fault_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (gnt_any) begin
                owner   <= gnt_d ? OWNER_D : OWNER_IF;
                fault_q <= req_fault;
                addr_q  <= req_addr;
                if (gnt_d) wdata_q <= bus.d_wdata;
            end
            if (state == ST_CAP) begin
                if (owner == OWNER_IF) if_rdata_q <= bus.mem_rdata;
                else                   d_rdata_q  <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_fault  = bus.if_done & fault_q;
    assign bus.d_fault   = bus.d_done & fault_q;
    assign bus.arb_flag  = fetch_pri;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: Memory model plus an operation-level reference model.
// Latency: n/a.
// Backpressure: requests are held until their done pulse, as a datapath would.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    mem_access_ctrl_if bus ();

    mem_access_ctrl dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Physical memory seen by the DUT, and the contents the bench expects.
    logic [15:0] mem     [0:8191];
    logic [15:0] ref_mem [0:8191];
    logic [15:0] exp_if_rdata;
    logic [15:0] exp_d_rdata;
    bit          fetch_turn;

    int rd_cnt   = 0;
    int wr_cnt   = 0;
    int both_cnt = 0;
    int oob_cnt  = 0;

    // Memory behaviour: write on memW, read data valid the cycle after memR.
    always @(posedge CLK) begin
        if (bus.memW) mem[bus.mem_addr[12:0]] <= bus.mem_wdata;
        if (bus.memR) bus.mem_rdata <= mem[bus.mem_addr[12:0]];
        if (bus.memR) rd_cnt <= rd_cnt + 1;
        if (bus.memW) wr_cnt <= wr_cnt + 1;
        if (bus.memR && bus.memW) both_cnt <= both_cnt + 1;
        if ((bus.memR || bus.memW) && bus.mem_addr >= 16'd8192) oob_cnt <= oob_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic bit is_oob(input logic [15:0] addr);
        return int'(addr) >= 8192;
    endfunction

    // Cycles from the IDLE sampling cycle to the done pulse.
    function automatic int op_lat(input bit is_d, input bit we, input logic [15:0] addr);
        if (is_oob(addr)) return 1;
        if (is_d && we)   return 2;
        return 3;
    endfunction

    task automatic wait_done(output int lat, output int who);
        lat = 0;
        who = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (bus.if_done || bus.d_done) begin
                lat = c;
                who = int'({bus.d_done, bus.if_done});
                break;
            end
        end
    endtask

    task automatic check_done(input bit is_d, input bit we, input logic [15:0] addr,
                              input logic [15:0] wdata, input string tag);
        bit f;
        f = is_oob(addr);
        chk({tag, ".fault"}, is_d ? bus.d_fault : bus.if_fault, f);
        if (!f) begin
            if (is_d && we) begin
                ref_mem[addr[12:0]] = wdata;
                chk({tag, ".mem"}, mem[addr[12:0]], wdata);
            end else if (is_d) begin
                exp_d_rdata = ref_mem[addr[12:0]];
            end else begin
                exp_if_rdata = ref_mem[addr[12:0]];
            end
        end
        chk({tag, ".if_rdata"}, bus.if_rdata, exp_if_rdata);
        chk({tag, ".d_rdata"}, bus.d_rdata, exp_d_rdata);
    endtask

    function automatic int n_reads(input bit is_d, input bit we, input logic [15:0] addr);
        return (!is_oob(addr) && !(is_d && we)) ? 1 : 0;
    endfunction

    function automatic int n_writes(input bit is_d, input bit we, input logic [15:0] addr);
        return (!is_oob(addr) && is_d && we) ? 1 : 0;
    endfunction

    task automatic do_op(input bit is_d, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata, input string tag);
        int lat, who, r0, w0;
        r0 = rd_cnt;
        w0 = wr_cnt;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        wait_done(lat, who);
        chk({tag, ".lat"}, lat, op_lat(is_d, we, addr));
        chk({tag, ".port"}, who, is_d ? 2 : 1);
        check_done(is_d, we, addr, wdata, tag);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        tick();
        chk({tag, ".pulse"}, {bus.if_done, bus.d_done}, 0);
        chk({tag, ".reads"}, rd_cnt - r0, n_reads(is_d, we, addr));
        chk({tag, ".writes"}, wr_cnt - w0, n_writes(is_d, we, addr));
    endtask

    // Both ports request in the same cycle; the loser keeps its request up.
    task automatic do_pair(input logic [15:0] ia, input bit dwe, input logic [15:0] da,
                           input logic [15:0] dw, input string tag);
        int lat, who, r0, w0, exp_r, exp_w;
        bit win_d;
        win_d = !fetch_turn;
        r0 = rd_cnt;
        w0 = wr_cnt;
        exp_r = n_reads(0, 0, ia) + n_reads(1, dwe, da);
        exp_w = n_writes(1, dwe, da);
        bus.if_req = 1'b1; bus.if_addr = ia;
        bus.d_req  = 1'b1; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dw;
        wait_done(lat, who);
        chk({tag, ".first"}, who, win_d ? 2 : 1);
        chk({tag, ".lat1"}, lat, win_d ? op_lat(1, dwe, da) : op_lat(0, 0, ia));
        if (win_d) begin
            check_done(1, dwe, da, dw, {tag, ".w"});
            bus.d_req = 1'b0;
        end else begin
            check_done(0, 0, ia, 16'h0, {tag, ".w"});
            bus.if_req = 1'b0;
        end
        wait_done(lat, who);
        chk({tag, ".second"}, who, win_d ? 1 : 2);
        chk({tag, ".lat2"}, lat, 1 + (win_d ? op_lat(0, 0, ia) : op_lat(1, dwe, da)));
        if (win_d) check_done(0, 0, ia, 16'h0, {tag, ".l"});
        else       check_done(1, dwe, da, dw, {tag, ".l"});
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        tick();
        chk({tag, ".pulse"}, {bus.if_done, bus.d_done}, 0);
        chk({tag, ".reads"}, rd_cnt - r0, exp_r);
        chk({tag, ".writes"}, wr_cnt - w0, exp_w);
        fetch_turn = !fetch_turn;
    endtask

    task automatic reset_dut();
        Reset = 1'b1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        repeat (2) tick();
        Reset = 1'b0;
        fetch_turn   = 1'b0;
        exp_if_rdata = 16'h0;
        exp_d_rdata  = 16'h0;
    endtask

    function automatic logic [15:0] pick_addr();
        if ($urandom_range(0, 7) == 0) return 16'(8190 + $urandom_range(0, 5));
        return 16'($urandom_range(0, 31));
    endfunction

    logic [15:0] ra, rb, rd;
    int          kind;

    initial begin
        Reset = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req  = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0;
        for (int i = 0; i < 8192; i++) begin
            mem[i]     = 16'h0;
            ref_mem[i] = 16'h0;
        end

        // Reset state
        reset_dut();
        chk("rst.memR", bus.memR, 0);
        chk("rst.memW", bus.memW, 0);
        chk("rst.mem_addr", bus.mem_addr, 0);
        chk("rst.mem_wdata", bus.mem_wdata, 0);
        chk("rst.done", {bus.if_done, bus.d_done, bus.if_fault, bus.d_fault}, 0);
        chk("rst.rdata", {bus.if_rdata, bus.d_rdata}, 0);
        chk("rst.arb_flag", bus.arb_flag, 0);

        // Store then load
        do_op(1, 1, 16'h0010, 16'hABCD, "t1_store");
        do_op(1, 0, 16'h0010, 16'h0000, "t2_load");

        // Contention: data first, then fetch, then data again
        mem[0] = 16'h1234;
        ref_mem[0] = 16'h1234;
        do_pair(16'h0000, 1'b0, 16'h0010, 16'h0, "t3_pair1");
        do_pair(16'h0000, 1'b0, 16'h0010, 16'h0, "t3_pair2");
        do_pair(16'h0000, 1'b1, 16'h0011, 16'h5555, "t3_pair3");

        // Range boundary
        do_op(1, 1, 16'h2000, 16'hDEAD, "t4_oob_store");
        do_op(1, 1, 16'h1FFF, 16'hBEEF, "t4_last_store");
        do_op(0, 0, 16'h1FFF, 16'h0, "t4_last_fetch");
        do_op(0, 0, 16'hFFFF, 16'h0, "t4_oob_fetch");

        // Reset during the RD cycle of a load
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0010;
        tick();
        chk("t5.memR_in_rd", bus.memR, 1);
        Reset = 1'b1;
        bus.d_req = 1'b0;
        tick();
        Reset = 1'b0;
        fetch_turn = 1'b0; exp_if_rdata = 16'h0; exp_d_rdata = 16'h0;
        chk("t5.memR_after", bus.memR, 0);
        chk("t5.d_done", bus.d_done, 0);
        chk("t5.d_rdata", bus.d_rdata, 0);
        tick();
        chk("t5.quiet", {bus.d_done, bus.if_done, bus.memR, bus.memW}, 0);
        do_op(1, 0, 16'h0010, 16'h0, "t5_load");

        // Reset during WR: the write still lands, no done pulse
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0020; bus.d_wdata = 16'h5A5A;
        tick();
        chk("t5w.memW_in_wr", bus.memW, 1);
        Reset = 1'b1;
        bus.d_req = 1'b0;
        tick();
        Reset = 1'b0;
        fetch_turn = 1'b0; exp_if_rdata = 16'h0; exp_d_rdata = 16'h0;
        ref_mem[16'h0020] = 16'h5A5A;
        chk("t5w.mem", mem[16'h0020], 16'h5A5A);
        chk("t5w.d_done", bus.d_done, 0);
        tick();
        do_op(1, 0, 16'h0020, 16'h0, "t5w_load");

        // Randomized mix of single ops and contended pairs
        for (int n = 0; n < 150; n++) begin
            ra   = pick_addr();
            rb   = pick_addr();
            rd   = 16'($urandom);
            kind = int'($urandom_range(0, 3));
            case (kind)
                0:       do_op(0, 0, ra, 16'h0, "rnd_fetch");
                1:       do_op(1, 1'($urandom_range(0, 1)), ra, rd, "rnd_d");
                default: do_pair(ra, 1'($urandom_range(0, 1)), rb, rd, "rnd_pair");
            endcase
        end

        // Full address sweep, including the first out-of-range word
        for (int a = 0; a <= 8192; a++) begin
            do_op(1, 1, 16'(a), 16'hABCD, "sweep_wr");
            do_op(1, 0, 16'(a), 16'h0000, "sweep_rd");
        end

        chk("never_both_strobes", both_cnt, 0);
        chk("never_oob_strobe", oob_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
